gpio_pad_ctrl: RTL and testbench

Parametrised GPIO pad-configuration controller for the openframe user area: it owns the static pad control bits (drive mode, input disable, trip/slew select, holdover, analog enable/select/polarity) for every pad instead of tying them to loopback constants. Software-side writes land in a shadow register bank; a commit request walks the pads and copies shadow to active one pad at a time, limiting simultaneous pad mode switching. Instantiated beside the user core inside the openframe project wrapper, driving the `gpio_*` pad-config outputs.

---
 rtl/gpio_pad_ctrl_pkg.sv | 30 +++
 rtl/gpio_pad_cfg_bank.sv | 39 +++
 rtl/gpio_pad_ctrl.sv | 134 +++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared types and constants for the GPIO pad-configuration controller.
// Config word layout, reset default word and commit FSM states.
package gpio_pad_ctrl_pkg;

  localparam int CFG_W = 11;

  localparam int DM0         = 0;
  localparam int DM1         = 1;
  localparam int DM2         = 2;
  localparam int INP_DIS     = 3;
  localparam int IB_MODE_SEL = 4;
  localparam int VTRIP_SEL   = 5;
  localparam int SLOW_SEL    = 6;
  localparam int HOLDOVER    = 7;
  localparam int ANALOG_EN   = 8;
  localparam int ANALOG_SEL  = 9;
  localparam int ANALOG_POL  = 10;

  typedef logic [CFG_W-1:0] cfg_t;

  // Input-only pad with the input buffer disabled.
  localparam cfg_t CFG_DEFAULT = 11'h009;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/gpio_pad_cfg_bank.sv
// Shadow and active configuration banks, one CFG_W word per pad.
// Ports: clk/rst_n, shadow write (wr_*), indexed copy (cp_*), active out.
module gpio_pad_cfg_bank
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int NUM_PADS = 44,
  parameter int AW       = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic                          wr_bcast,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [CFG_W-1:0]              wr_data,
  input  logic                          cp_en,
  input  logic [AW-1:0]                 cp_idx,
  output logic [NUM_PADS-1:0][CFG_W-1:0] active
);

  logic [NUM_PADS-1:0][CFG_W-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        shadow[i] <= CFG_DEFAULT;
        active[i] <= CFG_DEFAULT;
      end
    end else begin
      for (int i = 0; i < NUM_PADS; i++) begin
        // Out-of-range wr_addr matches no pad: accepted, dropped.
        if (wr_en && (wr_bcast || wr_addr == AW'(i)))
          shadow[i] <= wr_data;
        if (cp_en && cp_idx == AW'(i))
          active[i] <= shadow[i];
      end
    end
  end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad-config controller: shadow writes, paced shadow->active commit.
// Ports: cfg_* write, commit_*, gpio_* pad config; rd_* with GPIO_PAD_CTRL_READBACK_EN.
module gpio_pad_ctrl
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int NUM_PADS    = 44,
  parameter int STEP_CYCLES = 1,
  localparam int AW = $clog2(NUM_PADS)
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [AW-1:0]       cfg_addr,
  input  logic                cfg_bcast,
  input  logic [CFG_W-1:0]    cfg_wdata,
  input  logic                commit_req,
  output logic                commit_busy,
  output logic                commit_done,
`ifdef GPIO_PAD_CTRL_READBACK_EN
  input  logic [AW-1:0]       rd_addr,
  output logic [CFG_W-1:0]    rd_data,
`endif
  output logic [NUM_PADS-1:0] gpio_dm2,
  output logic [NUM_PADS-1:0] gpio_dm1,
  output logic [NUM_PADS-1:0] gpio_dm0,
  output logic [NUM_PADS-1:0] gpio_inp_dis,
  output logic [NUM_PADS-1:0] gpio_ib_mode_sel,
  output logic [NUM_PADS-1:0] gpio_vtrip_sel,
  output logic [NUM_PADS-1:0] gpio_slow_sel,
  output logic [NUM_PADS-1:0] gpio_holdover,
  output logic [NUM_PADS-1:0] gpio_analog_en,
  output logic [NUM_PADS-1:0] gpio_analog_sel,
  output logic [NUM_PADS-1:0] gpio_analog_pol
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  state_e                         state, state_d;
  logic [AW-1:0]                  idx, idx_d;
  logic [SW-1:0]                  step, step_d;
  logic                           cp_en;
  logic                           wr_en;
  logic [NUM_PADS-1:0][CFG_W-1:0] active;

  assign cfg_ready   = (state == ST_IDLE);
  assign commit_busy = (state != ST_IDLE);
  assign commit_done = (state == ST_DONE);
  assign wr_en       = cfg_valid & cfg_ready;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
      idx   <= '0;
      step  <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      step  <= step_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    step_d  = step;
    cp_en   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (commit_req) begin
          state_d = ST_COMMIT;
          idx_d   = '0;
          step_d  = '0;
        end
      end
      ST_COMMIT: begin
        if (step == SW'(STEP_CYCLES - 1)) begin
          cp_en  = 1'b1;
          step_d = '0;
          idx_d  = idx + AW'(1);
          if (idx == AW'(NUM_PADS - 1))
            state_d = ST_DONE;
        end else begin
          step_d = step + SW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  gpio_pad_cfg_bank #(
    .NUM_PADS (NUM_PADS),
    .AW       (AW)
  ) u_bank (
    .clk      (clk),
    .rst_n    (resetb),
    .wr_en    (wr_en),
    .wr_bcast (cfg_bcast),
    .wr_addr  (cfg_addr),
    .wr_data  (cfg_wdata),
    .cp_en    (cp_en),
    .cp_idx   (idx),
    .active   (active)
  );

  always_comb begin
    for (int i = 0; i < NUM_PADS; i++) begin
      gpio_dm0[i]         = active[i][DM0];
      gpio_dm1[i]         = active[i][DM1];
      gpio_dm2[i]         = active[i][DM2];
      gpio_inp_dis[i]     = active[i][INP_DIS];
      gpio_ib_mode_sel[i] = active[i][IB_MODE_SEL];
      gpio_vtrip_sel[i]   = active[i][VTRIP_SEL];
      gpio_slow_sel[i]    = active[i][SLOW_SEL];
      gpio_holdover[i]    = active[i][HOLDOVER];
      gpio_analog_en[i]   = active[i][ANALOG_EN];
      gpio_analog_sel[i]  = active[i][ANALOG_SEL];
      gpio_analog_pol[i]  = active[i][ANALOG_POL];
    end
  end

`ifdef GPIO_PAD_CTRL_READBACK_EN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)
      rd_data <= CFG_DEFAULT;
    else if (int'(rd_addr) < NUM_PADS)
      rd_data <= active[rd_addr];
    else
      rd_data <= '0;
  end
`endif

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: STEP_CYCLES=1 and 3 instances, shared stimulus.
// Commit scoreboard queues shadow words and pops them at each pad step.
module tb_gpio_pad_ctrl;
  import gpio_pad_ctrl_pkg::*;

  localparam int P  = 44;
  localparam int AW = $clog2(P);

  typedef struct {
    int         pad;
    logic [CFG_W-1:0] w;
  } ent_t;

  logic             clk = 1'b0;
  logic             resetb = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_bcast = 1'b0;
  logic             commit_req = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [AW-1:0]    rd_addr = AW'(20);
  logic [CFG_W-1:0] cfg_wdata = '0;

  logic             cfg_ready [2];
  logic             commit_busy [2];
  logic             commit_done [2];
  logic [P-1:0]     obs [2][11];
`ifdef GPIO_PAD_CTRL_READBACK_EN
  logic [CFG_W-1:0] rd_data [2];
`endif

  logic [CFG_W-1:0] sh [2][P];
  logic [CFG_W-1:0] act [2][P];
  logic [CFG_W-1:0] exp_rd [2];
  int               k [2];
  ent_t             q [2][$];
  int               n_assert = 0;
  int               n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gpio_pad_ctrl #(
      .NUM_PADS    (P),
      .STEP_CYCLES ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk              (clk),
      .resetb           (resetb),
      .cfg_valid        (cfg_valid),
      .cfg_ready        (cfg_ready[g]),
      .cfg_addr         (cfg_addr),
      .cfg_bcast        (cfg_bcast),
      .cfg_wdata        (cfg_wdata),
      .commit_req       (commit_req),
      .commit_busy      (commit_busy[g]),
      .commit_done      (commit_done[g]),
`ifdef GPIO_PAD_CTRL_READBACK_EN
      .rd_addr          (rd_addr),
      .rd_data          (rd_data[g]),
`endif
      .gpio_dm2         (obs[g][2]),
      .gpio_dm1         (obs[g][1]),
      .gpio_dm0         (obs[g][0]),
      .gpio_inp_dis     (obs[g][3]),
      .gpio_ib_mode_sel (obs[g][4]),
      .gpio_vtrip_sel   (obs[g][5]),
      .gpio_slow_sel    (obs[g][6]),
      .gpio_holdover    (obs[g][7]),
      .gpio_analog_en   (obs[g][8]),
      .gpio_analog_sel  (obs[g][9]),
      .gpio_analog_pol  (obs[g][10])
    );
  end

  function automatic int steps(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < P; i++) begin
        sh[d][i]  = CFG_DEFAULT;
        act[d][i] = CFG_DEFAULT;
      end
      k[d] = -1;
      q[d].delete();
      exp_rd[d] = CFG_DEFAULT;
    end
  endtask

  task automatic model_edge(int d);
    ent_t e;
    if (k[d] >= 0) begin
      k[d]++;
      if (k[d] % steps(d) == 0 && k[d] <= P * steps(d)) begin
        e = q[d].pop_front();
        act[d][e.pad] = e.w;
      end
      if (k[d] > P * steps(d)) k[d] = -1;
    end else begin
      if (cfg_valid)
        for (int i = 0; i < P; i++)
          if (cfg_bcast || int'(cfg_addr) == i)
            sh[d][i] = cfg_wdata;
      if (commit_req) begin
        k[d] = 0;
        for (int i = 0; i < P; i++)
          q[d].push_back('{i, sh[d][i]});
      end
    end
  endtask

  task automatic check_all();
    logic [P-1:0] e;
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < 11; f++) begin
        for (int i = 0; i < P; i++) e[i] = act[d][i][f];
        chk($sformatf("d%0d_field%0d", d, f),
            64'(obs[d][f]), 64'(e));
      end
      chk($sformatf("d%0d_busy", d),
          64'(commit_busy[d]), 64'(k[d] >= 0));
      chk($sformatf("d%0d_done", d),
          64'(commit_done[d]), 64'(k[d] == P * steps(d)));
      chk($sformatf("d%0d_ready", d),
          64'(cfg_ready[d]), 64'(k[d] < 0));
`ifdef GPIO_PAD_CTRL_READBACK_EN
      chk($sformatf("d%0d_rd", d),
          64'(rd_data[d]), 64'(exp_rd[d]));
`endif
    end
  endtask

  task automatic tick();
    logic [CFG_W-1:0] pr [2];
    for (int d = 0; d < 2; d++)
      pr[d] = (int'(rd_addr) < P) ? act[d][rd_addr] : '0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      model_edge(d);
      if (!resetb) reset_model();
      exp_rd[d] = resetb ? pr[d] : CFG_DEFAULT;
    end
    check_all();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  initial begin
    reset_model();
    #2 resetb = 1'b0;
    #1 check_all();
    ticks(2);
    resetb = 1'b1;
    tick();

    // out-of-range address: dropped, commit keeps defaults
    cfg_valid = 1'b1;
    cfg_addr  = AW'(50);
    cfg_wdata = 11'h7FF;
    tick();
    cfg_valid = 1'b0;
    pulse_commit();
    ticks(140);

    // single pad write then commit
    cfg_valid = 1'b1;
    cfg_addr  = AW'(5);
    cfg_wdata = 11'h0E6;
    tick();
    cfg_valid = 1'b0;
    tick();
    pulse_commit();
    ticks(140);

    // broadcast write then commit
    cfg_valid = 1'b1;
    cfg_bcast = 1'b1;
    cfg_wdata = 11'h007;
    tick();
    cfg_valid = 1'b0;
    cfg_bcast = 1'b0;
    pulse_commit();
    ticks(140);

    // write + commit same cycle, ignored re-request, held write
    cfg_valid  = 1'b1;
    cfg_addr   = AW'(7);
    cfg_wdata  = 11'h155;
    commit_req = 1'b1;
    tick();
    cfg_valid  = 1'b0;
    commit_req = 1'b0;
    ticks(5);
    pulse_commit();
    cfg_valid = 1'b1;
    cfg_addr  = AW'(9);
    cfg_wdata = 11'h2AA;
    ticks(140);
    cfg_valid = 1'b0;
    pulse_commit();
    ticks(140);

    // async reset at pad 20 of the fast instance
    pulse_commit();
    ticks(21);
    resetb = 1'b0;
    #1;
    reset_model();
    check_all();
    tick();
    resetb = 1'b1;
    ticks(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
